// File: rtl/div_operand_entry_if.sv
// Signal bundle between the operand-entry controller and its neighbours:
// keypad decoder, divider core and 7-segment display multiplexer.
interface div_operand_entry_if #(
  parameter int DIGITS = 2
);
  localparam int W = 4 * DIGITS;

  logic         key_valid;
  logic [3:0]   key_code;
  logic         clr;
  logic         div_done;
  logic [6:0]   div_q;
  logic [6:0]   div_r;
  logic [W-1:0] A_bin;
  logic [W-1:0] B_bin;
  logic         div_start;
  logic         busy;
  logic         err;
  logic [6:0]   Q_lat;
  logic [6:0]   R_lat;
  logic [15:0]  disp_val;
  logic [2:0]   state_dbg;

  // The environment (keypad, divider, display) drives the master side.
  modport master (
    output key_valid, key_code, clr, div_done, div_q, div_r,
    input  A_bin, B_bin, div_start, busy, err, Q_lat, R_lat, disp_val, state_dbg
  );

  modport slave (
    input  key_valid, key_code, clr, div_done, div_q, div_r,
    output A_bin, B_bin, div_start, busy, err, Q_lat, R_lat, disp_val, state_dbg
  );
endinterface

// File: rtl/div_operand_entry.sv
// Keypad operand-entry controller: shifts hex digits into A and B, starts the
// divider, latches Q/R, guards against B = 0 and a hung divider.
module div_operand_entry #(
  parameter int DIGITS  = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic               clk,
  input  logic               rst,
  div_operand_entry_if.slave bus
);
  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_ENTER_A   = 3'd0,
    S_ENTER_B   = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_SHOW      = 3'd4,
    S_ERR       = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [6:0]    q_lat_q, q_lat_d;
  logic [6:0]    r_lat_q, r_lat_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [15:0]   disp_q, disp_d;

  logic [W-1:0]  a_shift;
  logic [W-1:0]  b_shift;
  logic          last_digit;

  assign a_shift    = (a_q << 4) | W'(bus.key_code);
  assign b_shift    = (b_q << 4) | W'(bus.key_code);
  assign last_digit = (cnt_q == LAST_DIGIT);

  always_comb begin
    // NOTE: every _d starts from its held value, so no branch below can leave one unassigned and infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    q_lat_d = q_lat_q;
    r_lat_d = r_lat_q;

    case (state_q)
      S_ENTER_A: begin
        if (bus.key_valid) begin
          a_d = a_shift;
          if (last_digit) begin
            cnt_d   = '0;
            state_d = S_ENTER_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_ENTER_B: begin
        if (bus.key_valid) begin
          b_d = b_shift;
          if (last_digit) begin
            cnt_d   = '0;
            state_d = (b_shift == '0) ? S_ERR : S_START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT_DONE;
      end

      // A done on the final timeout cycle still completes normally.
      S_WAIT_DONE: begin
        if (bus.div_done) begin
          q_lat_d = bus.div_q;
          r_lat_d = bus.div_r;
          state_d = S_SHOW;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      // The key that leaves SHOW/ERR is already the first digit of the new A.
      S_SHOW, S_ERR: begin
        if (bus.key_valid) begin
          a_d     = W'(bus.key_code);
          b_d     = '0;
          cnt_d   = CW'(1);
          state_d = S_ENTER_A;
        end
      end

      default: state_d = S_ENTER_A;
    endcase

    if (bus.clr) begin
      state_d = S_ENTER_A;
      a_d     = '0;
      b_d     = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      q_lat_d = '0;
      r_lat_d = '0;
    end

    // Status outputs are registered from the next state so they align with it.
    start_d = (state_d == S_START);
    busy_d  = (state_d == S_START) || (state_d == S_WAIT_DONE);
    err_d   = (state_d == S_ERR);

    // The display follows the current registers, one cycle behind them.
    case (state_q)
      S_ENTER_A:                       disp_d = 16'(a_q);
      S_ENTER_B, S_START, S_WAIT_DONE: disp_d = 16'({a_q, b_q});
      S_SHOW:                          disp_d = {1'b0, q_lat_q, 1'b0, r_lat_q};
      S_ERR:                           disp_d = 16'hEEEE;
      default:                         disp_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      q_lat_q <= '0;
      r_lat_q <= '0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      q_lat_q <= q_lat_d;
      r_lat_q <= r_lat_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.A_bin     = a_q;
  assign bus.B_bin     = b_q;
  assign bus.div_start = start_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
  assign bus.Q_lat     = q_lat_q;
  assign bus.R_lat     = r_lat_q;
  assign bus.disp_val  = disp_q;
  assign bus.state_dbg = state_q;
endmodule

// File: doc/div_operand_entry.md
Name: div_operand_entry

Overview:
- Operand-entry controller that sits directly upstream of the divider core.
- Consumes decoded keypad nibbles, one pulse per key press, and assembles them into two 8-bit hex operands, A and B.
- Issues a one-cycle start to the divider, waits for its done, and latches Q/R.
- Presents a 16-bit display word to the 7-segment multiplexer.
- Guards against B = 0 and against a divider that never completes.

Parameters:
- DIGITS, 2, hex nibbles per operand; operand width is 4*DIGITS = 8.
- TIMEOUT, 1024, cycles allowed in WAIT_DONE before flagging an error.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle pulse: a debounced key press is present on key_code.
- key_code  in  4  hex value of the pressed key, 0x0–0xF; every key is a digit.
- clr  in  1  level or pulse; aborts entry and returns to ENTER_A.
- div_done  in  1  divider completion pulse.
- div_q  in  7  divider quotient, valid when div_done=1.
- div_r  in  7  divider remainder, valid when div_done=1.
- A_bin  out  8  dividend operand.
- B_bin  out  8  divisor operand.
- div_start  out  1  one-cycle start pulse to the divider.
- busy  out  1  high in START and WAIT_DONE.
- err  out  1  high in ERR state.
- Q_lat  out  7  latched quotient.
- R_lat  out  7  latched remainder.
- disp_val  out  16  four hex nibbles for the display.
- state_dbg  out  3  state encoding, for debug.

Behaviour:
- Reset state: rst=1 at a clk edge gives state ENTER_A. All of A_bin, B_bin, Q_lat, R_lat, digit count, timeout counter and disp_val are 0. div_start, busy and err are 0.
- States:
  - ENTER_A=0
  - ENTER_B=1
  - START=2
  - WAIT_DONE=3
  - SHOW=4
  - ERR=5
- ENTER_A:
  - On key_valid: A_bin <= {A_bin[3:0], key_code}; digit count++.
  - When the DIGITS-th digit is accepted: count <= 0, go to ENTER_B on the same edge.
- ENTER_B:
  - Same shift rule into B_bin.
  - On the last digit: if the new B value is 0, go to ERR; otherwise go to START.
- START:
  - div_start=1 for exactly this one cycle; busy=1.
  - Timeout counter cleared.
  - Next state is WAIT_DONE unconditionally.
- WAIT_DONE:
  - busy=1; counter increments each cycle.
  - div_done=1: Q_lat<=div_q, R_lat<=div_r, go to SHOW.
  - Counter reaches TIMEOUT-1 without done: go to ERR.
  - If done arrives on the same cycle the counter reaches TIMEOUT-1, done wins.
- SHOW and ERR:
  - Hold all registers.
  - On key_valid: A_bin <= {4'h0, key_code}, B_bin <= 0, count <= 1, err cleared, go to ENTER_A. The key is the first digit of the new A.
- Key handling:
  - key_valid in START or WAIT_DONE is ignored; no operand change.
  - Latency: key_valid at edge n means the new A_bin/B_bin is visible after edge n.
  - div_start asserts the cycle after the last B digit is accepted.
- clr:
  - Highest priority after rst, in every state.
  - Next state ENTER_A; A_bin, B_bin, count, Q_lat and R_lat cleared; err=0.
  - A coincident key_valid is dropped.
  - A div_done arriving after clr from WAIT_DONE is ignored, because the block is no longer in WAIT_DONE.
- div_done outside WAIT_DONE is ignored.
- disp_val:
  - ENTER_A: {8'h00, A_bin}.
  - ENTER_B, START, WAIT_DONE: {A_bin, B_bin}.
  - SHOW: {1'b0, Q_lat, 1'b0, R_lat}.
  - ERR: 16'hEEEE.
- disp_val is registered; it updates one cycle after the state or operand change.
- rst asserted mid-operation: same result as reset from power-up. A pending divider done is ignored.

Test Plan:
1. Reset held 8 cycles, then keys 4,5,0,7 each as a 1-cycle key_valid spaced 4 cycles apart -> A_bin=0x45, B_bin=0x07; div_start pulses once, 1 cycle after key 7; busy=1. Model div_done 20 cycles later with q=9, r=6 -> Q_lat=9, R_lat=6, state SHOW, disp_val=16'h0906.
2. Keys 1,2,0,0 -> ERR after the 4th key; div_start never asserts; err=1; disp_val=16'hEEEE. Next key 3 -> ENTER_A, A_bin=0x03, err=0.
3. Keys 8,1,0,3 with div_done never asserted -> ERR exactly TIMEOUT cycles after entering WAIT_DONE; busy drops on the same edge.
4. Key 9, then clr, then keys A,B,C,D -> A_bin=0xAB, B_bin=0xCD, div_start pulses. A clr coincident with key_valid leaves A_bin=0.
5. During WAIT_DONE, inject key_valid=1 with key_code=F -> A/B unchanged. A div_done pulse while in ENTER_B -> no state change and no latch.
6. rst asserted in WAIT_DONE, then div_done pulsed -> state ENTER_A, Q_lat=0, R_lat=0, all outputs at reset values.
